// File: rtl/jam_param_search_if.sv
// Bus between the job-assignment search engine and its controller / cost table.
// The master side starts a search and answers W/J lookups with Cost.
// The slave side is the search engine itself.
interface jam_param_search_if #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16
);
    logic                 start;
    logic                 mode;
    logic [IDX_W-1:0]     w;
    logic [IDX_W-1:0]     j;
    logic [COST_W-1:0]    cost;
    logic                 busy;
    logic                 valid;
    logic [CNT_W-1:0]     match_count;
    logic [SUM_W-1:0]     min_cost;
    logic [N*IDX_W-1:0]   best_perm;

    modport master (
        output start, mode, cost,
        input  w, j, busy, valid, match_count, min_cost, best_perm
    );

    modport slave (
        input  start, mode, cost,
        output w, j, busy, valid, match_count, min_cost, best_perm
    );
endinterface

// File: rtl/jam_param_search.sv
// Exhaustive job-assignment search engine.
// Walks all N! permutations in lexicographic order, sums the N costs of each
// one through the W/J -> Cost lookup, and keeps the optimum (MIN or MAX),
// the number of permutations reaching it and the first optimal permutation.
module jam_param_search #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    jam_param_search_if.slave bus
);
    // k runs 0..N inclusive during FETCH
    localparam int K_W = $clog2(N + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [K_W-1:0]      r_k;
    logic [IDX_W-1:0]    r_perm [N];
    logic [SUM_W-1:0]    r_sum;
    logic                r_mode;
    logic                r_first;
    logic [SUM_W-1:0]    r_best_sum;
    logic [CNT_W-1:0]    r_best_cnt;
    logic [N*IDX_W-1:0]  r_best_perm;
    logic [IDX_W-1:0]    r_w;
    logic [IDX_W-1:0]    r_j;
    logic                r_busy;
    logic                r_valid;
    logic [CNT_W-1:0]    r_match_count;
    logic [SUM_W-1:0]    r_min_cost;
    logic [N*IDX_W-1:0]  r_best_perm_out;

    logic [IDX_W-1:0]    w_perm_k;
    logic [N*IDX_W-1:0]  w_perm_flat;
    logic                w_better;
    logic                w_equal;
    logic [SUM_W-1:0]    w_upd_sum;
    logic [CNT_W-1:0]    w_upd_cnt;
    logic [N*IDX_W-1:0]  w_upd_perm;
    logic                w_has_pivot;
    logic                w_last;
    logic [IDX_W-1:0]    w_pval;
    logic [IDX_W-1:0]    w_sval;
    int                  w_pivot_idx;
    int                  w_succ_idx;
    logic [IDX_W-1:0]    w_next_perm [N];

    assign bus.w           = r_w;
    assign bus.j           = r_j;
    assign bus.busy        = r_busy;
    assign bus.valid       = r_valid;
    assign bus.match_count = r_match_count;
    assign bus.min_cost    = r_min_cost;
    assign bus.best_perm   = r_best_perm_out;

    // Flatten the working permutation: job of worker k sits at [k*IDX_W +: IDX_W]
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign w_perm_flat[gi*IDX_W +: IDX_W] = r_perm[gi];
        end
    endgenerate

    // Select perm[k] without indexing the array by a counter wider than needed
    always_comb begin
        w_perm_k = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k == K_W'(i)) w_perm_k = r_perm[i];
        end
    end

    // Compare the finished sum against the running best of this run
    always_comb begin
        w_better = r_first || (r_mode ? (r_sum > r_best_sum) : (r_sum < r_best_sum));
        w_equal  = !r_first && (r_sum == r_best_sum);
        w_upd_sum  = w_better ? r_sum : r_best_sum;
        w_upd_perm = w_better ? w_perm_flat : r_best_perm;
        if (w_better)     w_upd_cnt = CNT_W'(1);
        else if (w_equal) w_upd_cnt = r_best_cnt + CNT_W'(1);
        else              w_upd_cnt = r_best_cnt;
    end

    // Next lexicographic permutation: find pivot, swap with its successor,
    // reverse the (descending) suffix. No pivot means this is the last one.
    always_comb begin
        w_has_pivot = 1'b0;
        w_pivot_idx = 0;
        w_succ_idx  = 0;
        w_pval      = '0;
        w_sval      = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (r_perm[i] < r_perm[i+1]) begin
                w_has_pivot = 1'b1;
                w_pivot_idx = i;
                w_pval      = r_perm[i];
            end
        end
        // Suffix is descending, so the last larger element is the smallest larger one
        for (int x = 0; x < N; x++) begin
            if (x > w_pivot_idx && r_perm[x] > w_pval) begin
                w_succ_idx = x;
                w_sval     = r_perm[x];
            end
        end
        for (int i = 0; i < N; i++) begin
            w_next_perm[i] = r_perm[i];
            if (i == w_pivot_idx) begin
                w_next_perm[i] = w_sval;
            end else if (i > w_pivot_idx) begin
                for (int x = 0; x < N; x++) begin
                    if (x == N + w_pivot_idx - i)
                        w_next_perm[i] = (x == w_succ_idx) ? w_pval : r_perm[x];
                end
            end
        end
        w_last = !w_has_pivot;
    end

    // Search FSM, datapath and published results
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_k             <= '0;
            r_sum           <= '0;
            r_mode          <= 1'b0;
            r_first         <= 1'b0;
            r_best_sum      <= '0;
            r_best_cnt      <= '0;
            r_best_perm     <= '0;
            r_w             <= '0;
            r_j             <= '0;
            r_busy          <= 1'b0;
            r_valid         <= 1'b0;
            r_match_count   <= '0;
            r_min_cost      <= '0;
            r_best_perm_out <= '0;
            for (int i = 0; i < N; i++) r_perm[i] <= IDX_W'(i);
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_FETCH;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_mode  <= bus.mode;
                        r_first <= 1'b1;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        for (int i = 0; i < N; i++) r_perm[i] <= IDX_W'(i);
                    end
                end
                S_FETCH: begin
                    // Address goes out at step k, its cost is accumulated at step k+1
                    if (r_k < K_W'(N)) begin
                        r_w <= IDX_W'(r_k);
                        r_j <= w_perm_k;
                    end
                    if (r_k != '0) r_sum <= r_sum + SUM_W'(bus.cost);
                    if (r_k == K_W'(N)) r_state <= S_CMP;
                    else                r_k     <= r_k + K_W'(1);
                end
                S_CMP: begin
                    r_best_sum  <= w_upd_sum;
                    r_best_cnt  <= w_upd_cnt;
                    r_best_perm <= w_upd_perm;
                    r_first     <= 1'b0;
                    if (w_last) begin
                        r_match_count   <= w_upd_cnt;
                        r_min_cost      <= w_upd_sum;
                        r_best_perm_out <= w_upd_perm;
                        r_valid         <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= S_DONE;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    for (int i = 0; i < N; i++) r_perm[i] <= w_next_perm[i];
                    r_k     <= '0;
                    r_sum   <= '0;
                    r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
